// File: rtl/pci_pkg.sv
// pci_pkg: shared command codes, state encoding and defaults for the PCI target
package pci_pkg;
    localparam logic [3:0] CMD_CFG_RD = 4'b1010;
    localparam logic [3:0] CMD_CFG_WR = 4'b1011;
    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;
    localparam int RETRY_CLKS_DEF = 16;
    typedef enum logic [2:0] {IDLE, BUSY, CLAIM, WAIT, XFER, RETRY, TURN, TAR} state_t;
endpackage

// File: rtl/pci_par_gen.sv
// pci_par_gen: registered AD/CBE parity with its enable lagging the AD enable by one clock
module pci_par_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ad,
    input  logic [3:0]  cbe,
    input  logic        oe_ad_n,
    output logic        par,
    output logic        oe_par_n
);
    // parity covers the previous clock's AD/CBE, so value and enable both trail by one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par      <= 1'b0;
            oe_par_n <= 1'b1;
        end else begin
            par      <= ^ad ^ ^cbe;
            oe_par_n <= oe_ad_n;
        end
    end
endmodule

// File: rtl/pci_target_ctl.sv
// pci_target_ctl: PCI target sequencer bridging registered pad samples to a req/ack register backend
module pci_target_ctl
    import pci_pkg::*;
#(
    parameter int BAR_BITS   = 12,
    parameter int ADDR_W     = 10,
    parameter int RETRY_CLKS = RETRY_CLKS_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FRAME_I_N,
    input  logic              IRDY_I_N,
    input  logic              IDSEL_I,
    input  logic [31:0]       AD_I,
    input  logic [3:0]        CBE_I_N,
    input  logic [31:0]       BAR_BASE,
    input  logic              MEM_EN,
    output logic [31:0]       AD_O,
    output logic              OE_AD_N,
    output logic              PAR_O,
    output logic              OE_PAR_N,
    output logic              DEVSEL_O_N,
    output logic              OE_DEVSEL_N,
    output logic              TRDY_O_N,
    output logic              OE_TRDY_N,
    output logic              STOP_O_N,
    output logic              OE_STOP_N,
    output logic              BE_REQ,
    output logic              BE_WR,
    output logic              BE_CFG,
    output logic [ADDR_W-1:0] BE_ADDR,
    output logic [31:0]       BE_WDATA,
    output logic [3:0]        BE_BYTE_EN,
    input  logic [31:0]       BE_RDATA,
    input  logic              BE_ACK
);
    state_t state, state_nxt;
    logic frame_q, req_done, rd, addr_phase, hit, expire, master_gone, req_fire, unused_bar;
    logic [4:0] cnt;

    assign unused_bar  = ^BAR_BASE[BAR_BITS-1:0];
    assign rd          = ~BE_WR;
    assign addr_phase  = state == IDLE && !FRAME_I_N && frame_q;
    assign hit         = ((CBE_I_N == CMD_CFG_RD || CBE_I_N == CMD_CFG_WR) && IDSEL_I && AD_I[1:0] == 2'b00) ||
                         ((CBE_I_N == CMD_MEM_RD || CBE_I_N == CMD_MEM_WR) && MEM_EN &&
                          AD_I[31:BAR_BITS] == BAR_BASE[31:BAR_BITS]);
    assign expire      = cnt >= 5'(RETRY_CLKS - 1);
    assign master_gone = FRAME_I_N && IRDY_I_N;
    // reads request on entry to WAIT; writes request once IRDY shows the data is valid
    assign req_fire    = (state == CLAIM && rd) ||
                         (state == WAIT && !rd && !req_done && !IRDY_I_N && state_nxt == WAIT);

    // state register and FRAME history for address-phase edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            frame_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            frame_q <= FRAME_I_N;
        end
    end

    // next state: abort beats ack, ack beats retry expiry
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (addr_phase) state_nxt = hit ? CLAIM : BUSY;
            BUSY:    if (master_gone) state_nxt = IDLE;
            CLAIM:   state_nxt = WAIT;
            WAIT:    state_nxt = master_gone ? TURN : (req_done && BE_ACK) ? XFER : expire ? RETRY : WAIT;
            XFER:    if (!IRDY_I_N) state_nxt = TURN;
            RETRY:   if (FRAME_I_N) state_nxt = TURN;
            TURN:    state_nxt = TAR;
            default: state_nxt = IDLE;
        endcase
    end

    // bus outputs decoded from state; STOP joins TRDY in XFER while the master still wants a burst
    always_comb begin
        DEVSEL_O_N  = !(state inside {CLAIM, WAIT, XFER, RETRY});
        TRDY_O_N    = state != XFER;
        STOP_O_N    = !(state == RETRY || (state == XFER && !FRAME_I_N));
        OE_DEVSEL_N = !(state inside {CLAIM, WAIT, XFER, RETRY, TURN});
        OE_TRDY_N   = OE_DEVSEL_N;
        OE_STOP_N   = OE_DEVSEL_N;
        OE_AD_N     = !(rd && state inside {CLAIM, WAIT, XFER, RETRY});
    end

    // transaction latches, retry counter and the backend request pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt        <= '0;
            req_done   <= 1'b0;
            BE_REQ     <= 1'b0;
            BE_WR      <= 1'b0;
            BE_CFG     <= 1'b0;
            BE_ADDR    <= '0;
            BE_WDATA   <= '0;
            BE_BYTE_EN <= '0;
            AD_O       <= '0;
        end else begin
            BE_REQ <= req_fire;
            if (state == IDLE) cnt <= '0;
            else if (state == CLAIM || state == WAIT) cnt <= (cnt == 5'd31) ? cnt : cnt + 5'd1;
            if (state == IDLE) req_done <= 1'b0;
            else if (req_fire) req_done <= 1'b1;
            if (addr_phase && hit) begin
                BE_ADDR <= AD_I[ADDR_W+1:2];
                BE_WR   <= CBE_I_N[0];
                BE_CFG  <= CBE_I_N[3];
                AD_O    <= '0;
            end
            if (req_fire && !rd) begin
                BE_WDATA   <= AD_I;
                BE_BYTE_EN <= ~CBE_I_N;
            end
            if (state == WAIT && state_nxt == XFER && rd) AD_O <= BE_RDATA;
        end
    end

    pci_par_gen u_par (
        .clk      (CLK),
        .rst_n    (RST_N),
        .ad       (AD_O),
        .cbe      (CBE_I_N),
        .oe_ad_n  (OE_AD_N),
        .par      (PAR_O),
        .oe_par_n (OE_PAR_N)
    );
endmodule

// File: tb/tb_pci_target_ctl.sv
// tb_pci_target_ctl: directed transactions against hand-computed bus and backend values
module tb_pci_target_ctl;
    import pci_pkg::*;
    logic        CLK, RST_N, FRAME_I_N, IRDY_I_N, IDSEL_I, MEM_EN, BE_ACK;
    logic [31:0] AD_I, BAR_BASE, BE_RDATA, AD_O, BE_WDATA;
    logic [3:0]  CBE_I_N, BE_BYTE_EN;
    logic        OE_AD_N, PAR_O, OE_PAR_N, DEVSEL_O_N, OE_DEVSEL_N, TRDY_O_N, OE_TRDY_N;
    logic        STOP_O_N, OE_STOP_N, BE_REQ, BE_WR, BE_CFG;
    logic [9:0]  BE_ADDR;
    logic [4:0]  oe_all;
    logic [2:0]  ctl_n;
    int vecs = 0, errs = 0, reqs = 0, trdys = 0;

    pci_target_ctl dut (
        .CLK(CLK), .RST_N(RST_N), .FRAME_I_N(FRAME_I_N), .IRDY_I_N(IRDY_I_N), .IDSEL_I(IDSEL_I),
        .AD_I(AD_I), .CBE_I_N(CBE_I_N), .BAR_BASE(BAR_BASE), .MEM_EN(MEM_EN), .AD_O(AD_O),
        .OE_AD_N(OE_AD_N), .PAR_O(PAR_O), .OE_PAR_N(OE_PAR_N), .DEVSEL_O_N(DEVSEL_O_N),
        .OE_DEVSEL_N(OE_DEVSEL_N), .TRDY_O_N(TRDY_O_N), .OE_TRDY_N(OE_TRDY_N), .STOP_O_N(STOP_O_N),
        .OE_STOP_N(OE_STOP_N), .BE_REQ(BE_REQ), .BE_WR(BE_WR), .BE_CFG(BE_CFG), .BE_ADDR(BE_ADDR),
        .BE_WDATA(BE_WDATA), .BE_BYTE_EN(BE_BYTE_EN), .BE_RDATA(BE_RDATA), .BE_ACK(BE_ACK)
    );

    assign oe_all = {OE_DEVSEL_N, OE_TRDY_N, OE_STOP_N, OE_AD_N, OE_PAR_N};
    assign ctl_n  = {DEVSEL_O_N, TRDY_O_N, STOP_O_N};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // count request pulses and TRDY data phases mid-cycle
    always @(negedge CLK) begin
        if (BE_REQ) reqs++;
        if (!TRDY_O_N && !OE_TRDY_N) trdys++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        FRAME_I_N = 1; IRDY_I_N = 1; IDSEL_I = 0; AD_I = 0; CBE_I_N = 4'hF; BE_ACK = 0;
        repeat (n) tick();
    endtask

    task automatic addr(input logic [31:0] a, input logic [3:0] c, input logic sel);
        FRAME_I_N = 0; AD_I = a; CBE_I_N = c; IDSEL_I = sel;
        tick();
    endtask

    task automatic cfg_read(input bit stop_in_xfer);
        reqs = 0;
        addr(32'h0000_0004, CMD_CFG_RD, 1);
        FRAME_I_N = 1; IRDY_I_N = 0; IDSEL_I = 0; CBE_I_N = 4'h0; AD_I = 0;
        chk("cr_devsel", DEVSEL_O_N, 0);
        chk("cr_oe_ad", OE_AD_N, 0);
        chk("cr_oe_par_lag", OE_PAR_N, 1);
        chk("cr_ad_zero", AD_O, 0);
        chk("cr_addr", BE_ADDR, 1);
        chk("cr_cfg_wr", {BE_CFG, BE_WR}, 2'b10);
        tick();
        chk("cr_req", BE_REQ, 1);
        tick();
        chk("cr_req_drop", BE_REQ, 0);
        tick();
        BE_ACK = 1; BE_RDATA = 32'h1234_5678;
        tick();
        BE_ACK = 0;
        chk("cr_trdy", TRDY_O_N, 0);
        chk("cr_stop", STOP_O_N, 1);
        chk("cr_ad_o", AD_O, 32'h1234_5678);
        chk("cr_oe_par", OE_PAR_N, 0);
        if (stop_in_xfer) return;
        tick();
        IRDY_I_N = 1;
        chk("cr_par", PAR_O, 1);
        chk("cr_turn_ctl", ctl_n, 3'b111);
        chk("cr_turn_oe", oe_all, 5'b00010);
        tick();
        chk("cr_tar_oe", oe_all, 5'b11111);
        tick();
        chk("cr_idle_oe", oe_all, 5'b11111);
        chk("cr_reqs", reqs, 1);
    endtask

    task automatic mem_write;
        reqs = 0;
        addr(32'hF000_0010, CMD_MEM_WR, 0);
        FRAME_I_N = 1; IRDY_I_N = 0; AD_I = 32'hDEAD_BEEF; CBE_I_N = 4'b1100;
        chk("mw_devsel", DEVSEL_O_N, 0);
        chk("mw_oe_ad", OE_AD_N, 1);
        tick();
        tick();
        chk("mw_req", BE_REQ, 1);
        chk("mw_addr", BE_ADDR, 4);
        chk("mw_wr_cfg", {BE_CFG, BE_WR}, 2'b01);
        chk("mw_wdata", BE_WDATA, 32'hDEAD_BEEF);
        chk("mw_be", BE_BYTE_EN, 4'b0011);
        BE_ACK = 1;
        tick();
        BE_ACK = 0;
        chk("mw_trdy", TRDY_O_N, 0);
        chk("mw_oe_par", OE_PAR_N, 1);
        tick();
        IRDY_I_N = 1;
        chk("mw_turn_oe_par", OE_PAR_N, 1);
        tick();
        tick();
        chk("mw_reqs", reqs, 1);
    endtask

    task automatic miss(input logic [31:0] a, input logic en);
        logic seen = 1;
        reqs = 0; MEM_EN = en;
        addr(a, CMD_MEM_RD, 0);
        FRAME_I_N = 1; IRDY_I_N = 0;
        repeat (4) begin
            seen &= OE_DEVSEL_N;
            tick();
        end
        IRDY_I_N = 1;
        repeat (2) begin
            seen &= OE_DEVSEL_N;
            tick();
        end
        chk("miss_oe_devsel", seen, 1);
        chk("miss_reqs", reqs, 0);
        MEM_EN = 1;
    endtask

    task automatic mem_read_late(input int ack_cyc);
        reqs = 0;
        addr(32'hF000_0020, CMD_MEM_RD, 0);
        FRAME_I_N = (ack_cyc < 0) ? 1'b0 : 1'b1; IRDY_I_N = 0; CBE_I_N = 4'h0; AD_I = 0;
        for (int c = 1; c < 16; c++) tick();
        chk("rt_no_early_stop", {TRDY_O_N, STOP_O_N}, 2'b11);
        if (ack_cyc == 15) begin
            BE_ACK = 1; BE_RDATA = 32'h0BAD_F00D;
            tick();
            BE_ACK = 0;
            chk("rt_ack_wins", {TRDY_O_N, STOP_O_N}, 2'b01);
            chk("rt_ack_data", AD_O, 32'h0BAD_F00D);
            tick();
            IRDY_I_N = 1;
            tick();
            tick();
        end else begin
            tick();
            chk("rt_stop", {DEVSEL_O_N, TRDY_O_N, STOP_O_N}, 3'b010);
            BE_ACK = 1; BE_RDATA = 32'hFFFF_FFFF;
            tick();
            BE_ACK = 0;
            chk("rt_late_ack", {TRDY_O_N, STOP_O_N}, 2'b10);
            tick();
            chk("rt_hold", STOP_O_N, 0);
            FRAME_I_N = 1; IRDY_I_N = 1;
            tick();
            chk("rt_release", {STOP_O_N, OE_STOP_N}, 2'b10);
            tick();
            chk("rt_tar_oe", oe_all, 5'b11111);
            tick();
        end
        chk("rt_reqs", reqs, 1);
    endtask

    task automatic burst;
        reqs = 0; trdys = 0;
        addr(32'hF000_0008, CMD_MEM_RD, 0);
        FRAME_I_N = 0; IRDY_I_N = 0; CBE_I_N = 4'h0; AD_I = 0;
        tick();
        BE_ACK = 1; BE_RDATA = 32'hA5A5_0001;
        tick();
        BE_ACK = 0;
        chk("bu_trdy_stop", {TRDY_O_N, STOP_O_N}, 2'b00);
        chk("bu_data", AD_O, 32'hA5A5_0001);
        tick();
        FRAME_I_N = 1; IRDY_I_N = 1;
        chk("bu_turn_trdy", TRDY_O_N, 1);
        tick();
        tick();
        chk("bu_words", trdys, 1);
        chk("bu_reqs", reqs, 1);
    endtask

    task automatic abort;
        reqs = 0;
        addr(32'hF000_0030, CMD_MEM_RD, 0);
        FRAME_I_N = 1; IRDY_I_N = 1;
        tick();
        tick();
        chk("ab_turn", {DEVSEL_O_N, TRDY_O_N, OE_DEVSEL_N}, 3'b110);
        tick();
        chk("ab_tar_oe", oe_all, 5'b11111);
        chk("ab_reqs", reqs, 1);
    endtask

    initial begin
        RST_N = 1; MEM_EN = 1; BAR_BASE = 32'hF000_0000; BE_RDATA = 0;
        idle(0);
        #3 RST_N = 0;
        #4;
        chk("rst_ctl_oe", {ctl_n, oe_all}, 8'hFF);
        chk("rst_ad_par", {AD_O, PAR_O}, 0);
        chk("rst_be", {BE_REQ, BE_WR, BE_CFG, BE_ADDR, BE_BYTE_EN}, 0);
        chk("rst_wdata", BE_WDATA, 0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1;
        idle(2);
        cfg_read(0);
        idle(2);
        mem_write;
        idle(2);
        miss(32'hE000_0000, 1);
        idle(1);
        miss(32'hF000_0000, 0);
        idle(1);
        mem_read_late(-1);
        idle(2);
        mem_read_late(15);
        idle(2);
        burst;
        idle(2);
        abort;
        idle(2);
        cfg_read(1);
        #2 RST_N = 0;
        #1;
        chk("arst_oe", oe_all, 5'b11111);
        chk("arst_ctl", ctl_n, 3'b111);
        chk("arst_req_ad", {BE_REQ, AD_O}, 0);
        idle(0);
        @(posedge CLK);
        #1 RST_N = 1;
        chk("arst_release_oe", oe_all, 5'b11111);
        idle(2);
        cfg_read(0);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/pci_target_ctl.md
Name: pci_target_ctl

Overview:
- PCI 33 MHz target-transaction sequencer that sits between the registered PCI pad samples and a simple register backend.
- Decodes each address phase: configuration access via IDSEL, or memory access via a single BAR window.
- Drives DEVSEL/TRDY/STOP, the AD output enable and PAR on reads, with correct turnaround.
- Hands each single data phase to the backend through a req/ack handshake. Bursts end with disconnect-with-data; a slow backend triggers a retry.

Parameters:
- BAR_BITS, 12: size of memory window = 2**BAR_BITS bytes. BAR compare uses AD[31:BAR_BITS].
- ADDR_W, 10: backend dword-address width.
- RETRY_CLKS, 16: initial-latency limit, in clocks from DEVSEL assertion to TRDY.

Ports:
- CLK  in  1  PCI clock, all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- FRAME_I_N, IRDY_I_N, IDSEL_I  in  1 each  IOB-registered bus samples.
- AD_I  in  32  registered AD sample.
- CBE_I_N  in  4  registered C/BE# sample.
- BAR_BASE  in  32  programmed memory base; bits [31:BAR_BITS] used.
- MEM_EN  in  1  command-register memory-space enable.
- AD_O  out  32  read data.
- OE_AD_N  out  1  AD output enable, low = drive.
- PAR_O, OE_PAR_N  out  1 each  parity value and its enable (low = drive).
- DEVSEL_O_N, OE_DEVSEL_N  out  1 each  DEVSEL# value and enable.
- TRDY_O_N, OE_TRDY_N  out  1 each  TRDY# value and enable.
- STOP_O_N, OE_STOP_N  out  1 each  STOP# value and enable.
- BE_REQ  out  1  backend access request.
- BE_WR  out  1  1 = write.
- BE_CFG  out  1  1 = config space.
- BE_ADDR  out  ADDR_W  dword address.
- BE_WDATA  out  32  write data.
- BE_BYTE_EN  out  4  active-high byte enables.
- BE_RDATA  in  32  read data, valid with BE_ACK.
- BE_ACK  in  1  one-cycle completion pulse.

Behaviour:
- Reset (RST_N low, async):
  - state = IDLE.
  - All *_O_N = 1 and all OE_*_N = 1 (tristated).
  - AD_O = 0, PAR_O = 0.
  - BE_REQ = 0, BE_WR = 0, BE_CFG = 0, BE_ADDR = 0, BE_WDATA = 0, BE_BYTE_EN = 0.
  - Reset mid-transaction releases the bus immediately.
- Address phase: IDLE and FRAME_I_N = 0 on a cycle whose previous sample of FRAME_I_N was 1.
- Hit rules:
  - CFG hit: CBE_I_N in {1010, 1011} AND IDSEL_I AND AD_I[1:0] = 00.
  - MEM hit: CBE_I_N in {0110, 0111} AND MEM_EN AND AD_I[31:BAR_BITS] == BAR_BASE[31:BAR_BITS].
  - On a hit, latch command and address: BE_ADDR = AD_I[ADDR_W+1:2].
  - Otherwise go to BUSY and wait for FRAME_I_N = 1 and IRDY_I_N = 1, then IDLE.
- States:
  - IDLE → CLAIM on hit.
  - CLAIM: DEVSEL_O_N = 0, all target enables on (medium decode). For a read, OE_AD_N = 0 starting here, AD_O held at 0. Then → WAIT.
  - WAIT:
    - Write: when IRDY_I_N = 0, latch AD_I/~CBE_I_N and pulse BE_REQ.
    - Read: pulse BE_REQ on entry.
    - On BE_ACK, load AD_O = BE_RDATA for a read → XFER.
    - If RETRY_CLKS clocks elapse since CLAIM without BE_ACK: STOP_O_N = 0, TRDY_O_N = 1 → RETRY. BE_REQ drops; a late BE_ACK is ignored.
  - XFER: TRDY_O_N = 0. STOP_O_N = 0 if FRAME_I_N = 0 (burst → disconnect with data). Hold until IRDY_I_N = 0 → TURN.
  - RETRY: hold STOP_O_N = 0 until FRAME_I_N = 1 → TURN.
  - TURN: drive DEVSEL_O_N, TRDY_O_N and STOP_O_N = 1 for one clock, OE_AD_N = 1 → TAR.
  - TAR: all OE_*_N = 1 → IDLE.
- Write data phase: BE_WDATA and BE_BYTE_EN captured when IRDY_I_N = 0; write TRDY follows BE_ACK.
- Parity:
  - PAR_O = ^AD_O ^ ^CBE_I_N, registered.
  - OE_PAR_N lags OE_AD_N by exactly one clock, on both assertion and release.
  - Never driven on writes.
- BE_REQ is exactly one cycle wide, and there is one request per transaction.
- Simultaneous cases:
  - BE_ACK in the same cycle the retry counter expires: ACK wins → XFER.
  - FRAME_I_N rising while in WAIT (master abort): abandon the transaction and go to TURN. Drop BE_REQ; an outstanding write completes at the backend.
- Retry counter: 5 bits, saturating, cleared in IDLE.

Decomposition:
- Package pci_pkg holds:
  - command localparams: CMD_CFG_RD = 4'b1010, CMD_CFG_WR = 4'b1011, CMD_MEM_RD = 4'b0110, CMD_MEM_WR = 4'b0111;
  - the state encoding enum (IDLE, BUSY, CLAIM, WAIT, XFER, RETRY, TURN, TAR);
  - RETRY_CLKS default.
- Sub-module pci_par_gen: registered 36-input parity plus its one-clock-delayed enable.

Test Plan:
- Config read:
  - Stimulus: IDSEL = 1, CBE = 1010, AD = 0x0000_0004; backend ACK after 2 clocks with 0x1234_5678.
  - Required: DEVSEL low 1 clock after the address sample; TRDY low with AD_O = 0x1234_5678; PAR_O = 1 one clock later; all outputs tristated 2 clocks after the IRDY sample.
- Memory write:
  - Stimulus: BAR_BASE = 0xF000_0000, AD = 0xF000_0010, CBE = 0111, data 0xDEAD_BEEF, CBE = 1100.
  - Required: BE_ADDR = 4, BE_BYTE_EN = 0011, BE_WR = 1, one BE_REQ pulse.
- Miss:
  - Stimulus: AD = 0xE000_0000, or MEM_EN = 0.
  - Required: OE_DEVSEL_N stays 1 through the transaction; no BE_REQ.
- Retry:
  - Stimulus: backend never ACKs.
  - Required: STOP low, TRDY high, exactly 16 clocks after DEVSEL; release after FRAME deasserts; a late ACK is ignored.
- Burst:
  - Stimulus: FRAME held low during the data phase.
  - Required: TRDY and STOP both low; exactly one data word transferred.
- Reset:
  - Stimulus: assert RST_N during XFER.
  - Required: all OE_*_N = 1 in the same cycle (async); state IDLE on release.
